mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Shares the single 1024-bit line-wide memory bus between the instruction cache (I, read-only)
// and the write-through data cache (D, line read and line write). Round-robin grant, one
// transaction in flight, registered request to memory, per-transaction timeout.
// Sits between imem/dmem bus ports (b_*) and the memory controller.
// PARAMETERS
// ADDR_W   64    address width; line-aligned addresses only, low 7 bits forwarded unchanged
// LINE_W   1024  line width (bits)
// TIMEOUT  255   max cycles in BUSY waiting for m_dv before abort; 0 disables timeout
// PORTS
// clk        in   1       clock; all state updates on rising edge
// clr        in   1       asynchronous reset, active-high
// i_addr     in   ADDR_W  I-side line address
// i_rd       in   1       I-side line read request, held until i_dv
// i_rdata    out  LINE_W  line data to I-side (= m_rdata)
// i_dv       out  1       I-side completion strobe, 1 cycle
// d_addr     in   ADDR_W  D-side line address
// d_rd       in   1       D-side line read request, held until d_dv
// d_wr       in   1       D-side line write request, held until d_dv
// d_wdata    in   LINE_W  D-side write line
// d_rdata    out  LINE_W  line data to D-side (= m_rdata)
// d_dv       out  1       D-side completion strobe, 1 cycle
// m_addr     out  ADDR_W  memory address (registered)
// m_rd/m_wr  out  1       memory read/write strobes (registered, level, held until m_dv)
// m_wdata    out  LINE_W  memory write line (registered)
// m_rdata    in   LINE_W  memory read line, valid with m_dv
// m_dv       in   1       memory completion, 1 cycle
// busy       out  1       state != IDLE
// err        out  1       1-cycle pulse on timeout abort
// BEHAVIOUR
// - States IDLE, BUSY_I, BUSY_D, REL. Reset: IDLE, prio=0 (I preferred), m_rd=m_wr=0,
//   m_addr=0, m_wdata=0, timer=0, err=0; i_dv=d_dv=0; busy=0. Reset mid-transaction abandons it.
// - D request = d_rd|d_wr; if both set, read is issued (d_wr ignored until d_rd drops).
// - IDLE: only I req -> BUSY_I; only D req -> BUSY_D; both -> prio side (0:I, 1:D).
//   On the grant edge latch m_addr, m_wdata<=d_wdata, m_rd/m_wr; timer<=0.
//   Latency: request sampled at edge N, m_rd/m_wr high after edge N (cycle N+1).
// - BUSY_x: timer increments each cycle. On m_dv: x_dv=1 combinationally same cycle,
//   x_rdata=m_rdata; next edge clear m_rd/m_wr, prio <= other side, -> REL.
// - Timeout (TIMEOUT!=0, timer==TIMEOUT-1 with no m_dv): clear m_rd/m_wr, err=1 one cycle,
//   no x_dv, prio flips, -> REL. m_dv and timeout same cycle: m_dv wins, no err.
// - REL: 1 cycle, no grant, lets requester drop request after its dv; -> IDLE.
// - Back-to-back: continuous requests from both sides alternate I,D,I,D; each 2+memlat cycles.
// - m_dv in IDLE/REL ignored (no dv forwarded, no state change).
// - Request withdrawn during BUSY: transaction still completes; x_dv still pulses.
// - i_dv/d_dv never both high; at most one of m_rd/m_wr high.
// - Data outputs i_rdata/d_rdata are m_rdata unconditionally; only dv qualifies them.
// TESTING
// T1 i_rd, i_addr=0x1000, mem answers 3 cycles later -> m_rd=1 m_addr=0x1000 at N+1, i_dv 1 cycle, REL, IDLE.
// T2 i_rd and d_rd same cycle after reset -> I served first, then D; held both -> grants I,D,I,D.
// T3 d_wr, d_wdata=0xA5..A5, addr 0x2080 -> m_wr=1, m_wdata=0xA5..A5, m_rd=0; d_dv on m_dv.
// T4 d_rd=d_wr=1 -> m_rd only; after d_dv, d_rd drops, d_wr held -> write issued next.
// T5 TIMEOUT=8, no m_dv -> m_rd drops after 8 BUSY cycles, err 1 pulse, no i_dv; stray m_dv in IDLE ignored.
// T6 clr asserted in BUSY_D -> immediate IDLE, m_rd/m_wr=0, busy=0; next grant goes to I (prio=0).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// One line-wide memory bus port: a line address, read/write level strobes
// held until completion, a write line, a read line and a one-cycle
// completion strobe.
//
// The arbiter uses three of these: the I-cache and D-cache ports, where the
// cache is the master, and the memory-controller port, where the arbiter is
// the master.
//
// Signals
//   addr   master->slave  ADDR_W  line address (line aligned)
//   rd     master->slave  1       line read request, level
//   wr     master->slave  1       line write request, level
//   wdata  master->slave  LINE_W  write line
//   rdata  slave->master  LINE_W  read line, qualified by dv
//   dv     slave->master  1       completion strobe, one cycle
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int LINE_W = 1024
);
   logic [ADDR_W-1:0] addr;
   logic              rd;
   logic              wr;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              dv;

   modport master (
      output addr, rd, wr, wdata,
      input  rdata, dv
   );

   modport slave (
      input  addr, rd, wr, wdata,
      output rdata, dv
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single line-wide memory bus between the instruction cache
// (read-only) and the write-through data cache (line read and line write).
// Grants are round-robin, only one transaction is in flight at a time, the
// request to memory is registered, and every transaction has a timeout.
//
// Ports
//   clk     in      clock, all state updates on the rising edge
//   clr     in      asynchronous reset, active high
//   i_bus   slave   I-cache port (rd, addr; wr/wdata are not used)
//   d_bus   slave   D-cache port (rd, wr, addr, wdata)
//   m_bus   master  memory-controller port (registered addr/rd/wr/wdata)
//   busy    out     arbiter is not idle
//   err     out     one-cycle pulse when a transaction is aborted on timeout
//
// Parameters
//   ADDR_W   address width; addresses are passed through unchanged
//   LINE_W   line width in bits
//   TIMEOUT  cycles spent waiting for m_bus.dv before aborting, 0 = never
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int LINE_W  = 1024,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           clr,
   mem_arbiter_if.slave   i_bus,
   mem_arbiter_if.slave   d_bus,
   mem_arbiter_if.master  m_bus,
   output logic           busy,
   output logic           err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      REL
   } state_t;

   // The timer never needs to count past TIMEOUT-1.
   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST =
      TIMER_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   state_t            state;
   state_t            next_state;
   logic              prio;          // 0: I wins a tie, 1: D wins a tie
   logic [TIMER_W-1:0] timer;

   logic              req_i;
   logic              req_d;
   logic              grant_i;
   logic              grant_d;
   logic              in_busy;
   logic              done;
   logic              timed_out;
   logic [ADDR_W-1:0] grant_addr;
   logic [LINE_W-1:0] line_in;

   // Request decode and grant selection. A D request is a read or a write;
   // when both are raised the read goes first, the write waits until the
   // read request drops. Grants are only given from IDLE.
   always_comb begin
      req_i      = i_bus.rd;
      req_d      = d_bus.rd | d_bus.wr;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      if (state == IDLE) begin
         if (req_i && req_d) begin
            grant_i = ~prio;
            grant_d = prio;
         end else begin
            grant_i = req_i;
            grant_d = req_d;
         end
      end
      grant_addr = grant_d ? d_bus.addr : i_bus.addr;
      in_busy    = (state == BUSY_I) || (state == BUSY_D);
      done       = in_busy && m_bus.dv;
      // A completion arriving on the last allowed cycle beats the timeout.
      timed_out  = TIMEOUT_EN && in_busy && !m_bus.dv && (timer == TIMER_LAST);
   end

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. REL is a single dead cycle so a requester that just
   // saw its dv has time to drop its request before the next grant.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_i) begin
               next_state = BUSY_I;
            end else if (grant_d) begin
               next_state = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (done || timed_out) begin
               next_state = REL;
            end
         end
         REL:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs. Read data is forwarded unconditionally; only the completion
   // strobe of the side being served tells a cache the line is valid.
   always_comb begin
      line_in     = m_bus.rdata;
      busy        = (state != IDLE);
      i_bus.dv    = (state == BUSY_I) && m_bus.dv;
      d_bus.dv    = (state == BUSY_D) && m_bus.dv;
      i_bus.rdata = line_in;
      d_bus.rdata = line_in;
   end

   // Registered memory request, priority, timer and error pulse.
   // The request is latched on the grant edge and held until the transaction
   // either completes or times out; either way the other side gets priority.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         m_bus.addr  <= '0;
         m_bus.wdata <= '0;
         m_bus.rd    <= 1'b0;
         m_bus.wr    <= 1'b0;
         prio        <= 1'b0;
         timer       <= '0;
         err         <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               if (grant_i || grant_d) begin
                  m_bus.addr  <= grant_addr;
                  m_bus.wdata <= d_bus.wdata;
                  if (grant_i) begin
                     m_bus.rd <= 1'b1;
                     m_bus.wr <= 1'b0;
                  end else begin
                     m_bus.rd <= d_bus.rd;
                     m_bus.wr <= ~d_bus.rd;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               timer <= timer + 1'b1;
               if (done || timed_out) begin
                  m_bus.rd <= 1'b0;
                  m_bus.wr <= 1'b0;
                  prio     <= (state == BUSY_I);
                  err      <= timed_out;
               end
            end
            default: begin
               timer <= '0;
            end
         endcase
      end
   end

endmodule
